// File: rtl/fifo_sync_fwft_param_if.sv
// Handshake and status bundle for fifo_sync_fwft_param.
// The master drives requests; the slave is the FIFO itself.
interface fifo_sync_fwft_param_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic             flush;
  logic             write_en;
  logic [WIDTH-1:0] write_data;
  logic             read_en;
  logic [WIDTH-1:0] read_data;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;
  logic             err_clr;

  modport master (
    output flush, write_en, write_data, read_en, err_clr,
    input  read_data, empty, full, almost_empty, almost_full, level,
           overflow, underflow
  );

  modport slave (
    input  flush, write_en, write_data, read_en, err_clr,
    output read_data, empty, full, almost_empty, almost_full, level,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_fwft_param.sv
// Parametrised synchronous first-word-fall-through FIFO with arbitrary depth,
// occupancy level, almost flags, sticky error flags and synchronous flush.
module fifo_sync_fwft_param #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input logic                    clk,
  input logic                    rst,
  fifo_sync_fwft_param_if.slave  bus
);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_do_wr;
  logic             w_do_rd;
  logic             w_bypass;
  logic [LW:0]      w_level_next;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_empty      = (r_level == '0);
    w_full       = (r_level == LW'(DEPTH));
    w_do_wr      = bus.write_en & ~bus.flush & (~w_full  | bus.read_en);
    w_do_rd      = bus.read_en  & ~bus.flush & (~w_empty | bus.write_en);
    w_bypass     = w_empty & w_do_wr & w_do_rd;
    w_level_next = {1'b0, r_level} + (LW+1)'(w_do_wr) - (LW+1)'(w_do_rd);
  end

  always_ff @(posedge clk) begin
    if (w_do_wr && !rst) begin
      r_mem[r_wp] <= bus.write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.flush) begin
        r_wp    <= '0;
        r_rp    <= '0;
        r_level <= '0;
      end else begin
        if (w_do_wr) r_wp <= next_ptr(r_wp);
        if (w_do_rd) r_rp <= next_ptr(r_rp);
        r_level <= w_level_next[LW-1:0];
      end
      // Set takes priority over clear when both happen in one cycle.
      if (bus.write_en && !w_do_wr && !bus.flush) r_overflow <= 1'b1;
      else if (bus.err_clr)                       r_overflow <= 1'b0;
      if (bus.read_en && !w_do_rd && !bus.flush)  r_underflow <= 1'b1;
      else if (bus.err_clr)                       r_underflow <= 1'b0;
    end
  end

  assign bus.read_data    = w_bypass ? bus.write_data : r_mem[r_rp];
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_empty = (r_level <= LW'(AE_THRESH));
  assign bus.almost_full  = (r_level >= LW'(AF_THRESH));
  assign bus.level        = r_level;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_sync_fwft_param.sv
// Scoreboard bench for fifo_sync_fwft_param at DEPTH=5: stimulus queues expected
// read data, a negedge monitor pops and compares on every accepted read.
module tb_fifo_sync_fwft_param;
  localparam int W = 16;
  localparam int D = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_sync_fwft_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fifo_sync_fwft_param #(
    .WIDTH(W), .DEPTH(D), .AF_THRESH(D - 1), .AE_THRESH(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] sbq [$];
  int  mlevel = 0;
  logic mov = 1'b0;
  logic mun = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted read must present the oldest queued value.
  always @(negedge clk) begin
    if (!rst && !bus.flush && bus.read_en && (!bus.empty || bus.write_en)) begin
      if (sbq.size() == 0) begin
        check("sb_underrun", 32'd1, 32'd0);
      end else begin
        check("read_data", 32'(bus.read_data), 32'(sbq.pop_front()));
      end
    end
  end

  task automatic cyc(input logic we, input logic [W-1:0] wd, input logic re,
                     input logic fl, input logic ec, input logic rs);
    logic dw, dr;
    rst          = rs;
    bus.write_en = we;
    bus.write_data = wd;
    bus.read_en  = re;
    bus.flush    = fl;
    bus.err_clr  = ec;
    if (rs) begin
      mlevel = 0; mov = 1'b0; mun = 1'b0;
      sbq.delete();
    end else if (fl) begin
      mlevel = 0;
      sbq.delete();
    end else begin
      dw = we && (mlevel < D || re);
      dr = re && (mlevel > 0 || we);
      if (dw) sbq.push_back(wd);
      if (we && !dw) mov = 1'b1; else if (ec) mov = 1'b0;
      if (re && !dr) mun = 1'b1; else if (ec) mun = 1'b0;
      mlevel = mlevel + int'(dw) - int'(dr);
    end
    @(posedge clk);
    #1;
    check("level",        32'(bus.level),        32'(mlevel));
    check("empty",        32'(bus.empty),        32'(mlevel == 0));
    check("full",         32'(bus.full),         32'(mlevel == D));
    check("almost_empty", 32'(bus.almost_empty), 32'(mlevel <= 1));
    check("almost_full",  32'(bus.almost_full),  32'(mlevel >= D - 1));
    check("overflow",     32'(bus.overflow),     32'(mov));
    check("underflow",    32'(bus.underflow),    32'(mun));
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_ae",    32'(bus.almost_empty), 32'd1);

    // Fill 1..5
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      check("fill_level", 32'(bus.level), 32'(i));
      if (i == 1) check("fwft_head", 32'(bus.read_data), 32'h0001);
    end
    check("fill_af",   32'(bus.almost_full), 32'd1);
    check("fill_full", 32'(bus.full), 32'd1);

    // Overflow, then clear
    cyc(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_set",   32'(bus.overflow), 32'd1);
    check("ovf_level", 32'(bus.level), 32'd5);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovf_clr", 32'(bus.overflow), 32'd0);

    // Full simultaneous read+write, then drain
    cyc(1'b1, 16'h0006, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fullrw_level", 32'(bus.level), 32'd5);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("drain_empty", 32'(bus.empty), 32'd1);

    // Empty bypass, then underflow
    cyc(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    check("byp_level", 32'(bus.level), 32'd0);
    check("byp_unf",   32'(bus.underflow), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("unf_set", 32'(bus.underflow), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Wrap-around at level 2
    cyc(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      cyc(1'b1, 16'(16'h0102 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      check("wrap_level", 32'(bus.level), 32'd2);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap_empty", 32'(bus.empty), 32'd1);

    // Flush with overflow pending and write_en high
    for (int i = 0; i < 6; i++) cyc(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_flush_level", 32'(bus.level), 32'd3);
    cyc(1'b1, 16'h0BAD, 1'b1, 1'b1, 1'b0, 1'b0);
    check("flush_level", 32'(bus.level), 32'd0);
    check("flush_ovf",   32'(bus.overflow), 32'd1);
    check("flush_unf",   32'(bus.underflow), 32'd0);
    cyc(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_flush_head", 32'(bus.read_data), 32'h1234);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation with overflow set and write_en high
    cyc(1'b1, 16'h0300, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0301, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_ovf",     32'(bus.overflow), 32'd0);
    check("rst_level2",  32'(bus.level), 32'd0);
    idle();
    check("rst_no_store", 32'(bus.empty), 32'd1);

    check("sb_leftover", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
